sub_bytes_iter: RTL and testbench
=================================

# sub_bytes_iter

Iterative AES SubBytes stage. It accepts a 128-bit AES state over a valid/ready handshake and drives an external combinational `sbox` instance (or `LANES` instances), one byte per lane per cycle. Each substituted byte is written back into an internal buffer, and the full 128-bit result is presented downstream over a second valid/ready handshake. It sits between the round-key/AddRoundKey stage (upstream) and ShiftRows (downstream), and trades throughput for S-box area.

## Interface
- `LANES`, default 1: S-box lookups per cycle. Legal values are 1, 2, 4; any other value is an elaboration error. Pass count `NPASS = 16/LANES`.
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream holds a valid state on `state_in`.
- `in_ready`, output, 1: block can accept a state; high only in IDLE.
- `state_in`, input, 128: AES state; byte k = `state_in[127-8k -: 8]` (FIPS-197 order, byte 0 is MSB).
- `out_valid`, output, 1: `state_out` holds the substituted state.
- `out_ready`, input, 1: downstream accepts `state_out`.
- `state_out`, output, 128: substituted state, same byte order as `state_in`.
- `sbox_addr`, output, 8*LANES: lane j drives `sbox_addr[8j+7:8j]` to the j-th external sbox `addr`.
- `sbox_result`, input, 8*LANES: lane j receives the j-th sbox `result` combinationally, in the same cycle.

## Operation
- FSM states are IDLE, BUSY and DONE.
  - IDLE: `in_ready`=1, `out_valid`=0. On `in_valid && in_ready`, load `state_in` into `buf`, clear `cnt`, and go to BUSY.
  - BUSY: `in_ready`=0 and `out_valid`=0.
    - Lane j addresses byte `b = cnt*LANES + j`, with `sbox_addr` lane j = `buf` byte b.
    - At the clock edge, `buf` byte b is replaced by `sbox_result` lane j for every lane, and `cnt` increments.
    - When `cnt == NPASS-1` at the edge, go to DONE.
    - `cnt` is `log2(16)` bits wide and never wraps past `NPASS-1`.
  - DONE: `out_valid`=1 and `state_out` = `buf`, held stable. On `out_valid && out_ready`, go to IDLE.
- `state_out` is driven from `buf` at all times; it is meaningful only while `out_valid`=1.
- `sbox_addr` is driven from `buf` in all states. Its value outside BUSY is don't-care but must be deterministic (never X after reset).
- There is no overlap between transactions. A new input is accepted only in IDLE, so at most one state is in flight.
- `in_valid` asserted while not in IDLE is ignored. Upstream must hold `state_in` until the handshake completes.
- Downstream backpressure: DONE persists indefinitely while `out_ready`=0, with no change to `state_out`.
- The block never inspects data values. Substitution correctness depends entirely on the attached S-box.

## Timing
- Reset (synchronous, dominates all other inputs in the same cycle):
  - State goes to IDLE.
  - `in_ready`=1 from the first cycle after the reset edge.
  - `out_valid`=0.
  - `cnt`=0.
  - `buf`=0, so `state_out`=0 and `sbox_addr`=0.
- Reset asserted mid-BUSY or in DONE aborts the transaction. The partial result is discarded and no `out_valid` pulse follows.
- Latency: the input handshake at edge E is followed by BUSY for NPASS cycles, and `out_valid`=1 in the cycle after edge E+NPASS.
  - LANES=1: 16 cycles.
  - LANES=2: 8 cycles.
  - LANES=4: 4 cycles.
- Throughput with `out_ready` tied high: one state per NPASS+2 cycles (accept cycle, NPASS BUSY cycles, DONE cycle).
- The combinational path runs `buf` → `sbox_addr` → external sbox → `sbox_result` → `buf` within one cycle.
- `out_ready` and `in_valid` have no combinational path to any output. `in_ready` and `out_valid` are pure functions of FSM state.

## Test plan
- After reset, check `in_ready`=1, `out_valid`=0, `state_out`=0. Hold `in_valid`=0 for 50 cycles and confirm the outputs do not change.
- FIPS-197 vector with a correct S-box model attached and LANES=1:
  - Input `193de3bea0f4e22b9ac68d2ae9f84808`.
  - `state_out` = `d42711aee0bf98f1b8b45de51e415230`.
  - `out_valid` rises exactly 16 cycles after the accept edge.
- Boundary bytes:
  - All-zero input gives `636363...63`.
  - Input `00010253ff...` gives bytes `63 7c 77 ed 16 ...`.
  - Repeat with LANES=2 and LANES=4; check the same data with latency 8 and 4 cycles.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles in DONE; `state_out` stays stable and `in_ready`=0.
  - Pulse `in_valid` with other data during BUSY and DONE; it must be ignored.
  - Release `out_ready`; `in_ready`=1 on the next cycle.
- Reset mid-operation: assert `reset` at BUSY pass 7. The next cycle is IDLE with `out_valid`=0 and `state_out`=0. A following full transaction still yields the correct FIPS result.
- Back-to-back stream: 100 random states with `in_valid` and `out_ready` held high.
  - All outputs match the reference model, in order.
  - Spacing is exactly NPASS+2 cycles between `out_valid` pulses.

Source files
------------

// File: rtl/sub_bytes_iter_if.sv
// sub_bytes_iter_if: bundles the upstream handshake, the downstream handshake and the
// external S-box lane bus of sub_bytes_iter.
//
// Signals:
//   in_valid / in_ready / state_in     upstream 128-bit state handshake
//   out_valid / out_ready / state_out  downstream 128-bit state handshake
//   sbox_addr / sbox_result            LANES byte lanes to/from external combinational S-boxes
//
// Modports:
//   slave  - the SubBytes block itself
//   master - the surrounding environment (upstream, downstream and S-box instances)
interface sub_bytes_iter_if #(
    parameter int unsigned LANES = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [127:0]         state_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [127:0]         state_out;
    logic [8*LANES-1:0]   sbox_addr;
    logic [8*LANES-1:0]   sbox_result;

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        input  sbox_result,
        output in_ready,
        output out_valid,
        output state_out,
        output sbox_addr
    );

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        output sbox_result,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  sbox_addr
    );
endinterface

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes. Accepts a 128-bit state, pushes LANES bytes per
// cycle through external combinational S-boxes, writes each result back in place and
// presents the finished state downstream. Trades throughput for S-box count.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns to idle and clears the buffer
//   bus    sub_bytes_iter_if.slave (handshakes plus S-box lane bus); the interface
//          LANES parameter must equal this module's LANES
//
// Byte k of a state lives in bits [127-8k -: 8] (byte 0 is the MSB).
module sub_bytes_iter #(
    parameter int unsigned LANES = 1
) (
    input logic              clk,
    input logic              reset,
    sub_bytes_iter_if.slave  bus
);

    localparam int unsigned NPASS    = 16 / LANES;
    localparam logic [3:0]  LastPass = 4'(NPASS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("sub_bytes_iter: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    // Packed so that buf_q[15] is byte 0; byte k is buf_q[15-k].
    logic [15:0][7:0]        buf_q, buf_d;

    logic [LANES-1:0][3:0]   lane_idx;
    logic [LANES-1:0][7:0]   lane_addr;
    logic [LANES-1:0][7:0]   lane_res;

    assign lane_res      = bus.sbox_result;
    assign bus.sbox_addr = lane_addr;

    // Lane j works on byte cnt*LANES + j; addresses come straight from the buffer in
    // every state so the S-box inputs are never X once reset has cleared it.
    always_comb begin
        lane_idx  = '0;
        lane_addr = '0;
        for (int j = 0; j < int'(LANES); j++) begin
            lane_idx[j]  = 4'(int'(cnt_q) * int'(LANES) + j);
            lane_addr[j] = buf_q[4'd15 - lane_idx[j]];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    buf_d   = bus.state_in;
                    cnt_d   = 4'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int j = 0; j < int'(LANES); j++) begin
                    buf_d[4'd15 - lane_idx[j]] = lane_res[j];
                end
                // Counter holds on the last pass rather than wrapping.
                if (cnt_q == LastPass) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.state_out = buf_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one DUT per legal LANES value (1, 2, 4), each with its own
// arithmetic S-box model (GF(2^8) inverse plus affine map) on every lane.
module tb_sub_bytes_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst;
    logic [2:0]   iv;
    logic [2:0]   ordy;
    logic [2:0]   irdy;
    logic [2:0]   ov;
    logic [127:0] st_in  [3];
    logic [127:0] st_out [3];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse as a^254; zero maps to zero.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] s;
        s = ginv(a);
        return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = sbox_f(s[127 - 8*k -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int unsigned L = 1 << g;
            sub_bytes_iter_if #(.LANES(L)) ifc ();
            sub_bytes_iter #(.LANES(L)) dut (
                .clk   (clk),
                .reset (rst[g]),
                .bus   (ifc)
            );
            assign ifc.in_valid  = iv[g];
            assign ifc.state_in  = st_in[g];
            assign ifc.out_ready = ordy[g];
            assign irdy[g]       = ifc.in_ready;
            assign ov[g]         = ifc.out_valid;
            assign st_out[g]     = ifc.state_out;
            for (genvar j = 0; j < int'(L); j++) begin : g_sbox
                assign ifc.sbox_result[8*j +: 8] = sbox_f(ifc.sbox_addr[8*j +: 8]);
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int d);
        iv[d]    = 1'b0;
        ordy[d]  = 1'b0;
        st_in[d] = '0;
        rst[d]   = 1'b1;
        tick();
        tick();
        rst[d]   = 1'b0;
    endtask

    // Drives one transaction; returns cycles from accept edge to out_valid and the result.
    task automatic send_wait(input int d, input logic [127:0] data,
                             output int lat, output logic [127:0] res);
        int guard;
        guard = 0;
        while (!irdy[d] && guard < 100) begin
            tick();
            guard++;
        end
        iv[d]    = 1'b1;
        st_in[d] = data;
        tick();
        iv[d]    = 1'b0;
        lat      = 0;
        while (!ov[d] && lat < 100) begin
            tick();
            lat++;
        end
        res = st_out[d];
    endtask

    task automatic drain(input int d);
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
    endtask

    task automatic test_reset(input int d);
        reset_dut(d);
        n_cmp++;
        if (irdy[d] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready lanes=%0d got=%b want=1", 1 << d, irdy[d]);
        end
        n_cmp++;
        if (ov[d] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid lanes=%0d got=%b want=0", 1 << d, ov[d]);
        end
        n_cmp++;
        if (st_out[d] !== 128'h0) begin
            n_err++;
            $display("FAIL reset_state_out lanes=%0d got=%h want=0", 1 << d, st_out[d]);
        end
        for (int c = 0; c < 50; c++) begin
            tick();
            n_cmp++;
            if (irdy[d] !== 1'b1 || ov[d] !== 1'b0 || st_out[d] !== 128'h0) begin
                n_err++;
                $display("FAIL idle_hold lanes=%0d cyc=%0d got rdy=%b vld=%b out=%h want 1/0/0",
                         1 << d, c, irdy[d], ov[d], st_out[d]);
            end
        end
    endtask

    task automatic test_fips(input int d);
        int           lat;
        logic [127:0] res;
        send_wait(d, FipsIn, lat, res);
        n_cmp++;
        if (lat !== (16 >> d)) begin
            n_err++;
            $display("FAIL fips_latency lanes=%0d got=%0d want=%0d", 1 << d, lat, 16 >> d);
        end
        n_cmp++;
        if (res !== FipsOut) begin
            n_err++;
            $display("FAIL fips_data lanes=%0d got=%h want=%h", 1 << d, res, FipsOut);
        end
        drain(d);
    endtask

    task automatic test_boundary(input int d);
        int           lat;
        logic [127:0] res;
        logic [127:0] v;
        send_wait(d, 128'h0, lat, res);
        n_cmp++;
        if (res !== {16{8'h63}} || lat !== (16 >> d)) begin
            n_err++;
            $display("FAIL zero_input lanes=%0d got=%h lat=%0d want=%h lat=%0d",
                     1 << d, res, lat, {16{8'h63}}, 16 >> d);
        end
        drain(d);
        v = 128'h00010253ff102030405060708090a0b0;
        send_wait(d, v, lat, res);
        n_cmp++;
        if (res[127:88] !== 40'h637c77ed16) begin
            n_err++;
            $display("FAIL edge_bytes lanes=%0d got=%h want=637c77ed16", 1 << d, res[127:88]);
        end
        n_cmp++;
        if (res !== ref_sub(v) || lat !== (16 >> d)) begin
            n_err++;
            $display("FAIL edge_vector lanes=%0d got=%h lat=%0d want=%h lat=%0d",
                     1 << d, res, lat, ref_sub(v), 16 >> d);
        end
        drain(d);
    endtask

    task automatic test_backpressure(input int d);
        logic [127:0] a;
        logic [127:0] want;
        int           lat;
        a    = rand128();
        want = ref_sub(a);
        iv[d]    = 1'b1;
        st_in[d] = a;
        tick();
        // Accept edge done; now wiggle in_valid with other data.
        st_in[d] = ~a;
        lat      = 0;
        while (!ov[d] && lat < 100) begin
            iv[d] = lat[0];
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== (16 >> d)) begin
            n_err++;
            $display("FAIL bp_latency lanes=%0d got=%0d want=%0d", 1 << d, lat, 16 >> d);
        end
        for (int c = 0; c < 20; c++) begin
            iv[d] = c[0];
            tick();
            n_cmp++;
            if (st_out[d] !== want || irdy[d] !== 1'b0 || ov[d] !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold lanes=%0d cyc=%0d got out=%h rdy=%b vld=%b want %h/0/1",
                         1 << d, c, st_out[d], irdy[d], ov[d], want);
            end
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        n_cmp++;
        if (irdy[d] !== 1'b1 || ov[d] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release lanes=%0d got rdy=%b vld=%b want 1/0", 1 << d, irdy[d], ov[d]);
        end
    endtask

    task automatic test_reset_mid(input int d);
        int           npass;
        int           pass;
        int           lat;
        logic [127:0] res;
        npass    = 16 >> d;
        pass     = (npass > 7) ? 7 : npass - 1;
        iv[d]    = 1'b1;
        st_in[d] = rand128();
        tick();
        iv[d]    = 1'b0;
        for (int c = 0; c < pass; c++) tick();
        rst[d] = 1'b1;
        tick();
        rst[d] = 1'b0;
        n_cmp++;
        if (irdy[d] !== 1'b1 || ov[d] !== 1'b0 || st_out[d] !== 128'h0) begin
            n_err++;
            $display("FAIL mid_reset lanes=%0d got rdy=%b vld=%b out=%h want 1/0/0",
                     1 << d, irdy[d], ov[d], st_out[d]);
        end
        for (int c = 0; c < npass + 2; c++) begin
            tick();
            n_cmp++;
            if (ov[d] !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_no_pulse lanes=%0d cyc=%0d got=%b want=0", 1 << d, c, ov[d]);
            end
        end
        send_wait(d, FipsIn, lat, res);
        n_cmp++;
        if (res !== FipsOut || lat !== npass) begin
            n_err++;
            $display("FAIL mid_reset_recover lanes=%0d got=%h lat=%0d want=%h lat=%0d",
                     1 << d, res, lat, FipsOut, npass);
        end
        drain(d);
    endtask

    task automatic test_back_to_back(input int d);
        logic [127:0] q[$];
        logic [127:0] want;
        int           sent;
        int           got;
        int           last;
        int           cyc;
        int           npass;
        bit           acc;
        npass    = 16 >> d;
        sent     = 0;
        got      = 0;
        last     = -1;
        cyc      = 0;
        st_in[d] = rand128();
        iv[d]    = 1'b1;
        ordy[d]  = 1'b1;
        while (got < 100 && cyc < 100 * (npass + 2) + 50) begin
            acc = 1'b0;
            if (irdy[d] && iv[d]) begin
                q.push_back(ref_sub(st_in[d]));
                sent++;
                acc = 1'b1;
            end
            if (ov[d]) begin
                want = (q.size() > 0) ? q.pop_front() : 128'hx;
                n_cmp++;
                if (st_out[d] !== want) begin
                    n_err++;
                    $display("FAIL stream_data lanes=%0d idx=%0d got=%h want=%h",
                             1 << d, got, st_out[d], want);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== npass + 2) begin
                        n_err++;
                        $display("FAIL stream_spacing lanes=%0d idx=%0d got=%0d want=%0d",
                                 1 << d, got, cyc - last, npass + 2);
                    end
                end
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent == 100) iv[d] = 1'b0;
                else st_in[d] = rand128();
            end
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;
        n_cmp++;
        if (got !== 100) begin
            n_err++;
            $display("FAIL stream_count lanes=%0d got=%0d want=100", 1 << d, got);
        end
    endtask

    initial begin
        rst  = 3'b111;
        iv   = 3'b000;
        ordy = 3'b000;
        for (int i = 0; i < 3; i++) st_in[i] = '0;
        for (int d = 0; d < 3; d++) begin
            test_reset(d);
            test_fips(d);
            test_boundary(d);
            test_backpressure(d);
            test_reset_mid(d);
            test_back_to_back(d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
